// File: rtl/scan_bist_ctrl.sv
// Scan BIST controller: drives four equal-length scan chains with LFSR patterns,
// compacts the unloaded responses into a MISR and flags a golden-signature match.
module scan_bist_ctrl #(
   parameter int          CHAIN_LEN = 8,
   parameter int          PATTERNS  = 16,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter logic [15:0] GOLDEN    = 16'h0000
) (
   input  logic        CLK,
   input  logic        resetn,
   input  logic        Start,
   input  logic [3:0]  ScanChainOut,
   output logic [3:0]  ScanChainIN,
   output logic        SCANMODE,
   output logic        Busy,
   output logic        Done,
   output logic        Pass,
   output logic [15:0] Signature
);

   localparam int BIT_W = $clog2(CHAIN_LEN);
   localparam int PAT_W = $clog2(PATTERNS + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(PATTERNS - 1);
   localparam logic [PAT_W-1:0] PAT_ONE  = PAT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_CAPTURE,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [15:0]      r_lfsr;
   logic [15:0]      r_sig;
   logic [BIT_W-1:0] r_bit_cnt;
   logic [PAT_W-1:0] r_pat_cnt;
   logic [3:0]       r_scan_in;
   logic             r_scan_mode;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;

   state_t           w_state_nxt;
   logic [15:0]      w_lfsr_nxt;
   logic [15:0]      w_sig_nxt;
   logic [BIT_W-1:0] w_bit_nxt;
   logic [PAT_W-1:0] w_pat_nxt;
   logic [3:0]       w_scan_in_nxt;
   logic             w_scan_mode_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_pass_nxt;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [3:0] d);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {12'b0, d};
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_lfsr_nxt  = r_lfsr;
      w_sig_nxt   = r_sig;
      w_bit_nxt   = r_bit_cnt;
      w_pat_nxt   = r_pat_cnt;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (Start) begin
               w_state_nxt = S_SHIFT;
               w_lfsr_nxt  = SEED;
               w_sig_nxt   = '0;
               w_bit_nxt   = '0;
               w_pat_nxt   = '0;
            end
         end
         S_SHIFT: begin
            w_lfsr_nxt = lfsr_step(r_lfsr);
            // The first load has no prior response in the chains worth compacting.
            if (r_pat_cnt != '0) begin
               w_sig_nxt = misr_step(r_sig, ScanChainOut);
            end
            if (r_bit_cnt == BIT_LAST) begin
               w_bit_nxt   = '0;
               w_state_nxt = S_CAPTURE;
            end else begin
               w_bit_nxt = r_bit_cnt + BIT_ONE;
            end
         end
         S_CAPTURE: begin
            w_pat_nxt   = r_pat_cnt + PAT_ONE;
            w_state_nxt = (r_pat_cnt < PAT_LAST) ? S_SHIFT : S_FLUSH;
         end
         S_FLUSH: begin
            w_sig_nxt = misr_step(r_sig, ScanChainOut);
            if (r_bit_cnt == BIT_LAST) begin
               w_bit_nxt   = '0;
               w_state_nxt = S_DONE;
            end else begin
               w_bit_nxt = r_bit_cnt + BIT_ONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Pin values are derived from the upcoming state so every output is a flop.
      w_scan_in_nxt   = (w_state_nxt == S_SHIFT) ? w_lfsr_nxt[3:0] : 4'h0;
      w_scan_mode_nxt = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_FLUSH);
      w_busy_nxt      = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_CAPTURE) ||
                        (w_state_nxt == S_FLUSH);
      w_done_nxt      = (w_state_nxt == S_DONE);
      w_pass_nxt      = (w_state_nxt == S_DONE) && (w_sig_nxt == GOLDEN);
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_lfsr      <= SEED;
         r_sig       <= '0;
         r_bit_cnt   <= '0;
         r_pat_cnt   <= '0;
         r_scan_in   <= 4'h0;
         r_scan_mode <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_lfsr      <= w_lfsr_nxt;
         r_sig       <= w_sig_nxt;
         r_bit_cnt   <= w_bit_nxt;
         r_pat_cnt   <= w_pat_nxt;
         r_scan_in   <= w_scan_in_nxt;
         r_scan_mode <= w_scan_mode_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_pass      <= w_pass_nxt;
      end
   end

   assign ScanChainIN = r_scan_in;
   assign SCANMODE    = r_scan_mode;
   assign Busy        = r_busy;
   assign Done        = r_done;
   assign Pass        = r_pass;
   assign Signature   = r_sig;

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Scoreboard bench for scan_bist_ctrl: randomized runs against a schedule-level model,
// plus a short-chain instance pair for the fixed-pattern and golden-compare cases.
module tb_scan_bist_ctrl;

   localparam int          CL   = 8;
   localparam int          P    = 16;
   localparam logic [15:0] SD   = 16'hACE1;
   localparam logic [15:0] GOLD = 16'h0000;

   typedef struct packed {
      logic        sm;
      logic [3:0]  sin;
      logic [15:0] sig;
   } cyc_t;

   typedef struct packed {
      logic [15:0] sig;
      logic        pass;
   } res_t;

   logic        CLK = 1'b0;
   logic        resetn = 1'b1;
   logic        Start = 1'b0;
   logic [3:0]  so = 4'h0;
   logic [3:0]  sin;
   logic        smode, busy, done, pass;
   logic [15:0] sig;

   logic        Start_s = 1'b0;
   logic [3:0]  so_s = 4'hF;
   logic [3:0]  sin_s, sin_z;
   logic        sm_s, busy_s, done_s, pass_s;
   logic        sm_z, busy_z, done_z, pass_z;
   logic [15:0] sig_s, sig_z;

   int   n_chk = 0;
   int   n_err = 0;
   cyc_t q_cyc[$];
   res_t q_done[$];
   logic mon_on = 1'b0;
   logic [3:0] so_arr [0:1023];
   logic [3:0] so_prev[0:1023];

   always #5 CLK = ~CLK;

   scan_bist_ctrl #(.CHAIN_LEN(CL), .PATTERNS(P), .SEED(SD), .GOLDEN(GOLD)) dut (
      .CLK(CLK), .resetn(resetn), .Start(Start), .ScanChainOut(so),
      .ScanChainIN(sin), .SCANMODE(smode), .Busy(busy), .Done(done),
      .Pass(pass), .Signature(sig)
   );

   scan_bist_ctrl #(.CHAIN_LEN(4), .PATTERNS(1), .SEED(16'hACE1), .GOLDEN(16'h0055)) dut_s (
      .CLK(CLK), .resetn(resetn), .Start(Start_s), .ScanChainOut(so_s),
      .ScanChainIN(sin_s), .SCANMODE(sm_s), .Busy(busy_s), .Done(done_s),
      .Pass(pass_s), .Signature(sig_s)
   );

   scan_bist_ctrl #(.CHAIN_LEN(4), .PATTERNS(1), .SEED(16'hACE1), .GOLDEN(16'h0000)) dut_z (
      .CLK(CLK), .resetn(resetn), .Start(Start_s), .ScanChainOut(so_s),
      .ScanChainIN(sin_z), .SCANMODE(sm_z), .Busy(busy_z), .Done(done_z),
      .Pass(pass_z), .Signature(sig_z)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] m_lfsr(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [15:0] m_misr(input logic [15:0] s, input logic [3:0] d);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {12'b0, d};
   endfunction

   // Monitor: pops one expected entry per busy cycle and one result per Done rise.
   initial begin
      cyc_t e;
      res_t r;
      res_t last_res;
      logic prev_done;
      prev_done = 1'b0;
      last_res  = '0;
      forever begin
         @(negedge CLK);
         if (!resetn || !mon_on) begin
            prev_done = 1'b0;
         end else begin
            if (busy) begin
               if (q_cyc.size() == 0) begin
                  chk("busy_unexpected", 32'(busy), 32'd0);
               end else begin
                  e = q_cyc.pop_front();
                  chk("cycle", 32'({done, pass, smode, sin, sig}),
                      32'({2'b00, e.sm, e.sin, e.sig}));
               end
            end else begin
               chk("idle_pins", 32'({smode, sin}), 32'd0);
               if (done && !prev_done) begin
                  chk("done_latency", 32'(q_cyc.size()), 32'd0);
                  if (q_done.size() == 0) begin
                     chk("done_unexpected", 32'(done), 32'd0);
                  end else begin
                     r = q_done.pop_front();
                     last_res = r;
                     chk("result", 32'({sig, pass}), 32'({r.sig, r.pass}));
                  end
               end else if (done) begin
                  chk("done_hold", 32'({sig, pass}), 32'({last_res.sig, last_res.pass}));
               end
            end
            prev_done = done;
         end
      end
   end

   // mode 0: random responses, 1: all-zero responses, 2: replay previous run.
   task automatic do_run(input int mode, input bit pulses);
      int          t, pat, pos;
      bit          is_shift, is_flush;
      logic [15:0] lf, sg;
      cyc_t        e;
      t = P * (CL + 1) + CL;
      for (int c = 0; c < t; c++) begin
         case (mode)
            0:       so_arr[c] = 4'($urandom);
            1:       so_arr[c] = 4'h0;
            default: so_arr[c] = so_prev[c];
         endcase
         so_prev[c] = so_arr[c];
      end
      Start = 1'b1;
      @(posedge CLK);
      lf = SD;
      sg = 16'h0;
      for (int c = 0; c < t; c++) begin
         is_shift = 1'b0;
         is_flush = 1'b0;
         pat = c / (CL + 1);
         pos = c % (CL + 1);
         if (c >= P * (CL + 1)) begin
            is_flush = 1'b1;
            e = '{sm: 1'b1, sin: 4'h0, sig: sg};
         end else if (pos < CL) begin
            is_shift = 1'b1;
            e = '{sm: 1'b1, sin: lf[3:0], sig: sg};
         end else begin
            e = '{sm: 1'b0, sin: 4'h0, sig: sg};
         end
         q_cyc.push_back(e);
         if (is_shift) begin
            lf = m_lfsr(lf);
            if (pat >= 1) sg = m_misr(sg, so_arr[c]);
         end
         if (is_flush) sg = m_misr(sg, so_arr[c]);
      end
      q_done.push_back('{sig: sg, pass: (sg == GOLD)});
      #1 Start = 1'b0;
      for (int c = 0; c < t; c++) begin
         so    = so_arr[c];
         Start = pulses ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge CLK);
         #1;
      end
      Start = 1'b0;
   endtask

   task automatic small_test();
      int exp_sin[9] = '{1, 3, 7, 15, 0, 0, 0, 0, 0};
      int exp_sm[9]  = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
      Start_s = 1'b1;
      @(posedge CLK);
      #1 Start_s = 1'b0;
      for (int c = 0; c < 9; c++) begin
         chk("small_cycle", 32'({busy_s, done_s, sm_s, sin_s}),
             32'({1'b1, 1'b0, 1'(exp_sm[c]), 4'(exp_sin[c])}));
         @(posedge CLK);
         #1;
      end
      chk("small_done", 32'({busy_s, done_s}), 32'h1);
      chk("small_sig", 32'(sig_s), 32'h0055);
      chk("small_pass_g55", 32'(pass_s), 32'h1);
      chk("small_g0", 32'({busy_z, done_z, pass_z, sm_z, sin_z, sig_z}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0055}));
   endtask

   initial begin
      #1 resetn = 1'b0;
      #2;
      chk("reset_state", 32'({busy, done, pass, smode, sin, sig}), 32'd0);
      chk("reset_state_s", 32'({busy_s, done_s, pass_s, sm_s, sin_s, sig_s}), 32'd0);
      repeat (2) @(posedge CLK);
      #1 resetn = 1'b1;
      mon_on = 1'b1;

      small_test();
      repeat (3) begin @(posedge CLK); #1; end

      do_run(1, 1'b0);
      repeat (4) begin @(posedge CLK); #1; end
      do_run(0, 1'b1);
      do_run(0, 1'b1);
      do_run(2, 1'b0);
      repeat (3) begin @(posedge CLK); #1; end

      // Abandon a run part-way through the second pattern with an async reset.
      mon_on = 1'b0;
      Start  = 1'b1;
      @(posedge CLK);
      #1 Start = 1'b0;
      so = 4'hF;
      repeat (14) @(posedge CLK);
      #1;
      chk("pre_reset_active", 32'({busy, smode}), 32'h3);
      #2 resetn = 1'b0;
      #1;
      chk("reset_async", 32'({busy, done, pass, smode, sin, sig}), 32'd0);
      q_cyc.delete();
      q_done.delete();
      @(posedge CLK);
      #1 resetn = 1'b1;
      mon_on = 1'b1;
      repeat (6) begin
         @(posedge CLK);
         #1;
         chk("quiet_after_reset", 32'({busy, done, sig}), 32'd0);
      end

      do_run(0, 1'b0);
      repeat (5) begin @(posedge CLK); #1; end
      chk("queues_drained", 32'(q_cyc.size() + q_done.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/scan_bist_ctrl.md
# scan_bist_ctrl

On-chip scan test controller that drives the four scan chains of `EX_Core` from the initiator side. It generates pseudo-random shift-in patterns from an LFSR and toggles SCANMODE through shift/capture cycles. Unloaded chain responses are compacted into a MISR, and the final signature is compared against a golden value. It sits between the test access logic (Start/Done/Pass) and the core's scan pins, replacing a bench-driven scan stimulus.

## Interface
- CHAIN_LEN, 8, flops per scan chain (all 4 chains equal length, ≥2)
- PATTERNS, 16, number of patterns applied per run (≥1)
- SEED, 16'hACE1, LFSR load value at each run start (must be nonzero)
- GOLDEN, 16'h0000, expected final MISR signature
- CLK  in  1  single clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- Start  in  1  run request, sampled in IDLE/DONE
- ScanChainOut  in  4  scan outputs from core chains [3:0]
- ScanChainIN  out  4  scan inputs to core chains [3:0]
- SCANMODE  out  1  1 = shift, 0 = functional capture
- Busy  out  1  run in progress
- Done  out  1  run complete, held in DONE
- Pass  out  1  Signature == GOLDEN, valid while Done=1
- Signature  out  16  current MISR contents

## Operation
- States: IDLE, SHIFT, CAPTURE, FLUSH, DONE; all outputs registered.
- IDLE/DONE, Start=1: LFSR←SEED, MISR←0, pat_cnt←0, bit_cnt←0, go SHIFT.
- SHIFT (CHAIN_LEN cycles): SCANMODE=1, ScanChainIN=LFSR[3:0]. LFSR advances each edge. MISR samples ScanChainOut each edge only if pat_cnt≥1 (unloading previous response). After CHAIN_LEN edges go CAPTURE.
- CAPTURE (1 cycle): SCANMODE=0, ScanChainIN=0, LFSR/MISR hold, pat_cnt++. Next state is SHIFT if pat_cnt+1<PATTERNS, else FLUSH.
- FLUSH (CHAIN_LEN cycles): SCANMODE=1, ScanChainIN=0, MISR samples every edge, then DONE.
- DONE: Done=1, Busy=0, Pass=(Signature==GOLDEN), SCANMODE=0. Holds until Start=1 (new run).
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1. next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- MISR: next = {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {12'b0, ScanChainOut}.
- Start while Busy=1 is ignored. Start held high in DONE restarts immediately.
- Counters wrap-free: bit_cnt sized clog2(CHAIN_LEN), pat_cnt sized clog2(PATTERNS+1).

## Timing
- Reset (async assert, any state): IDLE; ScanChainIN=0, SCANMODE=0, Busy=0, Done=0, Pass=0, Signature=0, LFSR=SEED. A run in progress is abandoned with no partial Done.
- Start sampled high at edge E0: Busy=1, SCANMODE=1 after E0, first shift edge E1.
- Done rises after edge E0 + PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN, same edge Busy falls.
- ScanChainOut is sampled on the same edge that shifts the chain, so the value before the edge (last flop) is compacted. CHAIN_LEN samples per unload.
- Pass and Signature are stable for the whole DONE state.

## Test plan
- Reset: assert resetn=0 mid-SHIFT -> all outputs 0 immediately, state IDLE; after release, no activity until Start.
- CHAIN_LEN=4, PATTERNS=1, Start pulse -> ScanChainIN 1,3,7,F on shift cycles 1-4. SCANMODE 1,1,1,1,0,1,1,1,1. Done after 9 edges.
- Same config, ScanChainOut tied 4'hF -> Signature=16'h0055 at Done; GOLDEN=16'h0055 gives Pass=1, GOLDEN=0 gives Pass=0.
- ScanChainOut tied 0, default params -> Signature=0, Pass=1, Done after 16*9+8=152 edges.
- Start re-pulsed while Busy -> ignored, Done timing unchanged.
- Start asserted in DONE -> Done drops, MISR cleared, second run reproduces identical ScanChainIN sequence and Signature.
